// File: rtl/cla_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_seq_pkg
// Shared types and constants for the nibble-serial CLA add sequencer.
//   state_t   : controller FSM states (IDLE, ADD, RESP)
//   NIBBLE_W  : width of one carry-look-ahead slice
//   nibbles() : bit width of the nibble index counter for a given operand width
// -----------------------------------------------------------------------------
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   // Index counter width; never below one bit so a single-nibble adder still
   // has a legal counter.
   function automatic int nibbles(input int width);
      int n;
      n = width / NIBBLE_W;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cla_add_sequencer_cla4.sv
// -----------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-look-ahead adder.
//   a, b : 4-bit addends
//   cin  : carry in
//   s    : 4-bit sum
//   cout : carry out of bit 3
// Every carry is formed directly from generate/propagate terms and cin, so
// no carry ripples through the slice.
// -----------------------------------------------------------------------------
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic       c1;
   logic       c2;
   logic       c3;

   assign g = a & b;
   assign p = a ^ b;

   assign c1   = g[0] | (p[0] & cin);
   assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_add_sequencer.sv
// -----------------------------------------------------------------------------
// cla_add_sequencer
// Two-requester adder controller. A round-robin arbiter accepts one operand
// pair at a time; the add is then stepped one nibble per cycle through a
// single shared cla4_slice with the carry registered between nibbles, and the
// result is offered on a valid/ready response port.
//   clk, rst                      : clock, synchronous active-high reset
//   req0_valid/ready/a/b/cin      : requester 0 operand port
//   req1_valid/ready/a/b/cin      : requester 1 operand port
//   rsp_valid, rsp_ready          : response handshake
//   rsp_id                        : requester that owns the result
//   rsp_sum, rsp_cout             : (a + b + cin) mod 2^WIDTH and its carry
//   busy                          : high while in ADD or RESP
// -----------------------------------------------------------------------------
module cla_add_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             busy
);

   localparam int               NIBBLES  = WIDTH / NIBBLE_W;
   localparam int               IDX_W    = nibbles(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t                             state;
   state_t                             next_state;
   logic                               last_grant;
   logic                               grant;
   logic                               accept;
   logic                               last_nib;
   logic [IDX_W-1:0]                   idx;
   logic                               carry;
   logic [WIDTH-1:0]                   op_a;
   logic [WIDTH-1:0]                   op_b;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]   sum_q;
   logic [NIBBLE_W-1:0]                slice_s;
   logic                               slice_cout;

   // Round-robin arbiter: a tie goes to whoever was not served last.
   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Readies are forced low during reset so nothing is handed over while the
   // controller is being cleared.
   assign req0_ready = !rst && (state == IDLE) && !grant && req0_valid;
   assign req1_ready = !rst && (state == IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready || req1_ready;

   assign last_nib  = (idx == LAST_IDX);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign rsp_sum   = sum_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)    next_state = ADD;
         ADD:     if (last_nib)  next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // Operand registers shift down one nibble per ADD cycle, so the slice
   // always sees nibble[idx] in the low four bits.
   // NOTE: these registers carry no reset; they are always loaded on accept
   // before they are ever read, so a reset would only add fan-out.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= grant ? req1_a : req0_a;
         op_b <= grant ? req1_b : req0_b;
      end else if (state == ADD) begin
         op_a <= op_a >> NIBBLE_W;
         op_b <= op_b >> NIBBLE_W;
      end
   end

   cla4_slice u_slice (
      .a    (op_a[NIBBLE_W-1:0]),
      .b    (op_b[NIBBLE_W-1:0]),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // Arbitration history, nibble counter, inter-nibble carry and result.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         idx        <= '0;
         carry      <= 1'b0;
         sum_q      <= '0;
         rsp_cout   <= 1'b0;
         rsp_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  carry      <= grant ? req1_cin : req0_cin;
                  idx        <= '0;
                  rsp_id     <= grant;
                  last_grant <= grant;
               end
            end
            ADD: begin
               sum_q[idx] <= slice_s;
               carry      <= slice_cout;
               if (last_nib) begin
                  rsp_cout <= slice_cout;
                  idx      <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cla_add_sequencer
// Self-checking bench for cla_add_sequencer: a WIDTH=16 instance exercised by
// a directed vector table, random adds against a plain-arithmetic model,
// contention, backpressure and mid-ADD reset sequences, plus a WIDTH=4
// instance for the single-nibble case.
// -----------------------------------------------------------------------------
module tb_cla_add_sequencer;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // WIDTH=16 instance signals
   logic         req0_valid, req0_ready, req0_cin;
   logic         req1_valid, req1_ready, req1_cin;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;

   // WIDTH=4 instance signals
   logic         n4_req0_valid, n4_req0_ready, n4_req0_cin;
   logic         n4_req1_valid, n4_req1_ready, n4_req1_cin;
   logic [3:0]   n4_req0_a, n4_req0_b, n4_req1_a, n4_req1_b, n4_rsp_sum;
   logic         n4_rsp_valid, n4_rsp_ready, n4_rsp_id, n4_rsp_cout, n4_busy;

   int tests = 0;
   int fails = 0;

   cla_add_sequencer #(.WIDTH(W)) dut16 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .busy(busy)
   );

   cla_add_sequencer #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .req0_valid(n4_req0_valid), .req0_ready(n4_req0_ready), .req0_a(n4_req0_a), .req0_b(n4_req0_b),
      .req0_cin(n4_req0_cin),
      .req1_valid(n4_req1_valid), .req1_ready(n4_req1_ready), .req1_a(n4_req1_a), .req1_b(n4_req1_b),
      .req1_cin(n4_req1_cin),
      .rsp_valid(n4_rsp_valid), .rsp_ready(n4_rsp_ready), .rsp_id(n4_rsp_id), .rsp_sum(n4_rsp_sum),
      .rsp_cout(n4_rsp_cout), .busy(n4_busy)
   );

   typedef struct {
      bit          id;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the full-width unsigned add, carry in the top bit.
   function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic cin);
      return 17'(a) + 17'(b) + 17'(cin);
   endfunction

   function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      return 5'(a) + 5'(b) + 5'(cin);
   endfunction

   // One transaction on the 16-bit instance with rsp_ready held high.
   task automatic run16(input bit id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [15:0] sum, output logic cout, output logic rid, output int lat);
      int n;
      if (id) begin
         req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
      end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         tick();
         n++;
      end
      check("run16_ready_wait", n < 20, 1);
      tick();  // accept edge
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      sum  = rsp_sum;
      cout = rsp_cout;
      rid  = rsp_id;
      check("run16_busy_in_resp", busy, 1);
      tick();
   endtask

   task automatic run4(input bit id, input logic [3:0] a, input logic [3:0] b, input logic cin,
                       output logic [3:0] sum, output logic cout, output logic rid, output int lat);
      int n;
      if (id) begin
         n4_req1_a = a; n4_req1_b = b; n4_req1_cin = cin; n4_req1_valid = 1'b1;
      end else begin
         n4_req0_a = a; n4_req0_b = b; n4_req0_cin = cin; n4_req0_valid = 1'b1;
      end
      #1;
      n = 0;
      while (!(id ? n4_req1_ready : n4_req0_ready) && n < 20) begin
         tick();
         n++;
      end
      check("run4_ready_wait", n < 20, 1);
      tick();
      n4_req0_valid = 1'b0;
      n4_req1_valid = 1'b0;
      lat = 0;
      while (!n4_rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      sum  = n4_rsp_sum;
      cout = n4_rsp_cout;
      rid  = n4_rsp_id;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s;
      logic        c, rid;
      logic [3:0]  s4;
      logic [16:0] exp17;
      logic [4:0]  exp5;
      int          lat, n, got, cyc, acc, both, seen;
      bit          id;
      bit          q_id[$];
      logic [16:0] q_exp[$];

      vecs[0] = '{id: 1'b0, a: 16'h1234, b: 16'h0FFF, cin: 1'b0, sum: 16'h2233, cout: 1'b0};
      vecs[1] = '{id: 1'b1, a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, cout: 1'b1};
      vecs[2] = '{id: 1'b0, a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};
      vecs[3] = '{id: 1'b1, a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
      vecs[4] = '{id: 1'b0, a: 16'h00F0, b: 16'h0010, cin: 1'b0, sum: 16'h0100, cout: 1'b0};
      vecs[5] = '{id: 1'b1, a: 16'h0000, b: 16'h0000, cin: 1'b0, sum: 16'h0000, cout: 1'b0};
      vecs[6] = '{id: 1'b1, a: 16'h7FFF, b: 16'h0000, cin: 1'b1, sum: 16'h8000, cout: 1'b0};

      // Reset with both requesters asking: readies must stay low.
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      rsp_ready = 1'b1;
      n4_req0_valid = 1'b0; n4_req1_valid = 1'b0;
      n4_req0_a = '0; n4_req0_b = '0; n4_req0_cin = 1'b0;
      n4_req1_a = '0; n4_req1_b = '0; n4_req1_cin = 1'b0;
      n4_rsp_ready = 1'b1;
      tick();
      tick();
      check("reset_readies", {req0_ready, req1_ready}, 2'b00);
      check("reset_outputs", {rsp_valid, rsp_sum, rsp_cout, rsp_id, busy}, '0);
      check("reset_outputs_w4", {n4_rsp_valid, n4_rsp_sum, n4_rsp_cout, n4_rsp_id, n4_busy}, '0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      tick();

      // Directed vectors.
      for (int i = 0; i < 7; i++) begin
         run16(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, s, c, rid, lat);
         check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
         check($sformatf("vec%0d_cout", i), c, vecs[i].cout);
         check($sformatf("vec%0d_id", i), rid, vecs[i].id);
         check($sformatf("vec%0d_latency", i), lat, 4);
      end

      // Random adds against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         id = 1'($urandom_range(0, 1));
         req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
         req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
         exp17 = id ? ref16(req1_a, req1_b, req1_cin) : ref16(req0_a, req0_b, req0_cin);
         if (id) run16(id, req1_a, req1_b, req1_cin, s, c, rid, lat);
         else    run16(id, req0_a, req0_b, req0_cin, s, c, rid, lat);
         check($sformatf("rand%0d_sum_cout", i), {c, s}, exp17);
         check($sformatf("rand%0d_id", i), rid, id);
      end

      // Contention from reset: strict alternation starting with req0.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      got = 0; cyc = 0; both = 0;
      while (got < 4 && cyc < 200) begin
         if (req0_ready && req1_ready) both = 1;
         acc = 2;
         if (req0_ready) begin
            q_id.push_back(1'b0);
            q_exp.push_back(ref16(req0_a, req0_b, req0_cin));
            acc = 0;
         end else if (req1_ready) begin
            q_id.push_back(1'b1);
            q_exp.push_back(ref16(req1_a, req1_b, req1_cin));
            acc = 1;
         end
         if (rsp_valid && q_id.size() > 0) begin
            check($sformatf("cont%0d_grant_order", got), rsp_id, got % 2);
            check($sformatf("cont%0d_id", got), rsp_id, q_id.pop_front());
            check($sformatf("cont%0d_sum_cout", got), {rsp_cout, rsp_sum}, q_exp.pop_front());
            got++;
         end
         tick();
         cyc++;
         if (acc == 0) begin
            req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
         end else if (acc == 1) begin
            req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("cont_completed", got, 4);
      check("cont_readies_exclusive", both, 0);
      tick();

      // Backpressure: hold RESP with rsp_ready low while req1 is waiting.
      rsp_ready = 1'b0;
      req0_a = 16'hABCD; req0_b = 16'h1234; req0_cin = 1'b1;
      req0_valid = 1'b1;
      #1;
      n = 0;
      while (!req0_ready && n < 20) begin
         tick();
         n++;
      end
      check("bp_ready_wait", n < 20, 1);
      tick();
      req0_valid = 1'b0;
      req1_a = 16'h0005; req1_b = 16'h0006; req1_cin = 1'b0;
      req1_valid = 1'b1;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_latency", lat, 4);
      check("bp_result", {rsp_cout, rsp_sum, rsp_id}, {1'b0, 16'hBE02, 1'b0});
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_hold%0d", i),
               {rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready, busy},
               {1'b1, 16'hBE02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_complete", {rsp_valid, busy}, 2'b00);
      req1_valid = 1'b0;
      tick();

      // Reset in the second ADD cycle: the request is dropped.
      req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
      req0_valid = 1'b1;
      #1;
      n = 0;
      while (!req0_ready && n < 20) begin
         tick();
         n++;
      end
      check("mid_ready_wait", n < 20, 1);
      tick();
      req0_valid = 1'b0;
      tick();
      check("mid_busy_before_reset", busy, 1);
      rst = 1'b1;
      tick();
      check("mid_reset_outputs", {rsp_valid, rsp_sum, rsp_cout, rsp_id, busy}, '0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid) seen = 1;
      end
      check("mid_no_response", seen, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("mid_tie_grants_req0", {req0_ready, req1_ready}, 2'b10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // WIDTH=4 instance: single nibble, one-cycle latency.
      run4(1'b0, 4'h8, 4'h8, 1'b0, s4, c, rid, lat);
      check("w4_sum", s4, 4'h0);
      check("w4_cout", c, 1'b1);
      check("w4_id", rid, 1'b0);
      check("w4_latency", lat, 1);
      for (int i = 0; i < 8; i++) begin
         id = 1'($urandom_range(0, 1));
         n4_req0_a = 4'($urandom); n4_req0_b = 4'($urandom); n4_req0_cin = 1'($urandom);
         exp5 = ref4(n4_req0_a, n4_req0_b, n4_req0_cin);
         run4(id, n4_req0_a, n4_req0_b, n4_req0_cin, s4, c, rid, lat);
         check($sformatf("w4_rand%0d_sum_cout", i), {c, s4}, exp5);
         check($sformatf("w4_rand%0d_id", i), rid, id);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cla_add_sequencer.md
# cla_add_sequencer

Two-requester, nibble-serial adder controller built around a 4-bit carry-look-ahead slice. It arbitrates round-robin between two operand sources and accepts one WIDTH-bit add per transaction. The add is sequenced one 4-bit nibble per cycle through a single shared CLA slice, with the carry registered between nibbles. The result is returned on a valid/ready response port. It sits between the team's arithmetic requesters and the shared combinational adder datapath.

## Interface
- WIDTH, 16: operand/sum width; multiple of 4, ≥ 4. NIBBLES = WIDTH/4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 accepted on this edge when valid & ready.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result when valid & ready.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- rsp_cout  out  1  carry out of the MSB nibble.
- busy  out  1  high in ADD and RESP.

## Operation
- FSM states: IDLE, ADD, RESP.
- **IDLE.** Grant selection:
  - Only req0_valid is high: grant 0.
  - Only req1_valid is high: grant 1.
  - Both are high: grant the requester that is not `last_grant`.
  - `last_grant` resets to 1, so req0 wins the first tie.
- **IDLE accept.** reqN_ready = (state == IDLE) & grant == N & reqN_valid.
  - Ready is never high for both requesters in the same cycle.
  - On accept: capture a, b, cin into the operand and carry registers; nibble index = 0; rsp_id = grant; last_grant = grant; go to ADD.
- **ADD.** Each cycle:
  - Feed nibble[idx] of a, b and the carry register into cla4_slice.
  - Write the slice sum into rsp_sum[4·idx +: 4].
  - Carry register = slice cout; idx++.
  - When idx == NIBBLES-1 is processed: rsp_cout = slice cout; go to RESP.
- **RESP.** rsp_valid = 1.
  - rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready.
  - When rsp_valid & rsp_ready: go to IDLE.
- **Requester rule.** reqN_valid and its operands stay stable until ready. Deasserting valid before ready is permitted; the request is simply not taken.
- **Arithmetic.** Unsigned. rsp_cout is the true carry of the full-width add, identical to a single WIDTH-bit adder.
- **Reset values:**
  - state = IDLE; last_grant = 1; idx = 0; carry = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, busy = 0.
  - req0_ready = req1_ready = 0 in any cycle where rst = 1.
- **Reset mid-operation** (ADD or RESP): the transaction is dropped and no response is issued. IDLE arbitration resumes the cycle after rst deasserts.

## Timing
- **Accept latency.** Acceptance at edge E0 leaves the FSM in ADD. rsp_valid rises after edge E0 + NIBBLES; for WIDTH=16 that is 4 cycles after accept.
- **No overlap.** The FSM is in IDLE for at least one cycle between transactions.
  - Minimum period = NIBBLES + 2 cycles, with rsp_ready held high.
  - Peak throughput, WIDTH=16: one add per 6 cycles.
- **Combinational paths.** reqN_ready depends combinationally on state, reqN_valid and the other requester's valid. There is no combinational path from rsp_ready to any output.
- **Back-to-back requests.** Both valids held high continuously are granted in strict alternation: 0, 1, 0, 1…
- **Backpressure.** While rsp_ready is low, RESP holds indefinitely, all outputs are stable, and both readies are 0.
- **Critical path.** One cla4_slice plus the carry register.

## Structure
- Package cla_seq_pkg:
  - state enum {IDLE, ADD, RESP}.
  - NIBBLE_W = 4.
  - Function nibbles(WIDTH) for the index width.
- Sub-module cla4_slice: purely combinational 4-bit carry-look-ahead adder.
  - Inputs a[3:0], b[3:0], cin; outputs s[3:0], cout.
  - G = a&b, P = a^b, explicit look-ahead carry equations.
  - Instantiated once.
- Top module:
  - Round-robin arbiter logic.
  - FSM, index counter, carry register, result register.

## Test plan
- Single add, WIDTH=16: req0 a=0x1234, b=0x0FFF, cin=0 → rsp_sum=0x2233, rsp_cout=0, rsp_id=0; rsp_valid high exactly 4 cycles after accept.
- Full carry ripple: req1 a=0xFFFF, b=0x0000, cin=1 → rsp_sum=0x0000, rsp_cout=1, rsp_id=1.
- Contention:
  - Both valids high from reset → grant order 0, 1, 0, 1 over 4 transactions.
  - Readies are never simultaneously high.
  - Each result matches its requester's operands.
- Backpressure: rsp_ready low for 3 cycles in RESP → rsp_* stable, both readies 0; transaction completes on the first cycle with rsp_ready high.
- Reset mid-ADD: rst pulsed in the 2nd ADD cycle → rsp_valid never asserts for that request; all outputs at reset values; the next tie grants req0.
- WIDTH=4 instance: a=0x8, b=0x8, cin=0 → rsp_sum=0x0, rsp_cout=1, rsp_valid 1 cycle after accept.
